// File: rtl/tag_fill_controller_pkg.sv
// Shared types and constants for the tag fill controller and its PLRU helper.
package tag_fill_controller_pkg;

   typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_VICTIM, ST_WRITE} state_e;

   // A binary PLRU tree over n ways has n-1 internal nodes.
   function automatic int plru_nodes(input int ways);
      return ways - 1;
   endfunction

   localparam logic [7:0] LFSR_SEED = 8'h01;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/tag_fill_controller_plru_tree.sv
// Combinational tree-PLRU: node update for a touched way and victim walk from the root.
module tag_fill_controller_plru_tree
   import tag_fill_controller_pkg::*;
#(
   parameter int NUM_WAYS = 4,
   parameter int LOG_WAYS = 2
) (
   input  logic [plru_nodes(NUM_WAYS)-1:0] node_i,
   input  logic [LOG_WAYS-1:0]             touch_pos_i,
   output logic [plru_nodes(NUM_WAYS)-1:0] node_o,
   output logic [LOG_WAYS-1:0]             victim_o
);

   // Nodes are heap-ordered: children of node k are 2k+1 (lower) and 2k+2 (upper).
   always_comb begin
      int k;
      node_o   = node_i;
      victim_o = '0;
      k        = 0;
      for (int lvl = 0; lvl < LOG_WAYS; lvl++) begin
         node_o[k] = ~touch_pos_i[LOG_WAYS-1-lvl];
         k = 2*k + 1 + int'(touch_pos_i[LOG_WAYS-1-lvl]);
      end
      k = 0;
      for (int lvl = 0; lvl < LOG_WAYS; lvl++) begin
         victim_o[LOG_WAYS-1-lvl] = node_i[k];
         k = 2*k + 1 + int'(node_i[k]);
      end
   end

endmodule

// File: rtl/tag_fill_controller.sv
// Tag/valid store with tree-PLRU, fill victim selection and full-array flush.
// Define TAG_FILL_RANDOM_REPL_EN to replace PLRU with an LFSR victim when a line is full.
module tag_fill_controller
   import tag_fill_controller_pkg::*;
#(
   parameter int bits_for_tag           = 20,
   parameter int number_of_sets         = 4,
   parameter int log_of_number_of_sets  = 2,
   parameter int number_of_lines        = 64,
   parameter int log_of_number_of_lines = 6
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [log_of_number_of_lines-1:0]      lookup_index,
   output logic [bits_for_tag*number_of_sets-1:0] tag_set,
   output logic [number_of_sets-1:0]              valid_lanes,
   input  logic                                   touch_valid,
   input  logic [log_of_number_of_lines-1:0]      touch_index,
   input  logic [log_of_number_of_sets-1:0]       touch_pos,
   input  logic                                   fill_valid,
   output logic                                   fill_ready,
   input  logic [log_of_number_of_lines-1:0]      fill_index,
   input  logic [bits_for_tag-1:0]                fill_tag,
   output logic                                   fill_done,
   output logic [log_of_number_of_sets-1:0]       fill_pos,
   output logic                                   fill_evict,
   output logic [bits_for_tag-1:0]                fill_evict_tag,
   input  logic                                   flush_req,
   output logic                                   flush_busy
);

   localparam int TW = bits_for_tag;
   localparam int NW = number_of_sets;
   localparam int LW = log_of_number_of_sets;
   localparam int NL = number_of_lines;
   localparam int LL = log_of_number_of_lines;
   localparam int NN = plru_nodes(NW);
   localparam logic [LL:0] CNT_ONE = 1;

   logic [TW-1:0] tag_mem   [NL][NW];
   logic [NW-1:0] valid_mem [NL];

   state_e           state_q, state_d;
   logic [LL:0]      flush_cnt_q, flush_cnt_d;
   logic [LL-1:0]    fill_idx_q, fill_idx_d;
   logic [TW-1:0]    fill_tag_q, fill_tag_d;
   logic [LW-1:0]    vic_pos_q, vic_pos_d;
   logic             vic_valid_q, vic_valid_d;
   logic [TW-1:0]    vic_tag_q, vic_tag_d;
   logic             flush_pend_q, flush_pend_d;
   logic [NW*TW-1:0] tag_set_q, tag_set_d;
   logic [NW-1:0]    valid_lanes_q, valid_lanes_d;
   logic [LW-1:0]    repl_pos;

`ifdef TAG_FILL_RANDOM_REPL_EN
   logic [7:0] lfsr_q, lfsr_d;
   logic       unused_touch;

   assign lfsr_d       = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
   assign repl_pos     = lfsr_q[LW-1:0];
   assign unused_touch = ^{touch_valid, touch_index, touch_pos, lfsr_q[7:LW]};

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end
`else
   logic [NN-1:0] plru_mem [NL];
   logic [NN-1:0] touch_node_new, fill_node_new;
   logic [LW-1:0] unused_touch_victim;

   tag_fill_controller_plru_tree #(.NUM_WAYS(NW), .LOG_WAYS(LW)) u_plru_touch (
      .node_i      (plru_mem[touch_index]),
      .touch_pos_i (touch_pos),
      .node_o      (touch_node_new),
      .victim_o    (unused_touch_victim)
   );

   tag_fill_controller_plru_tree #(.NUM_WAYS(NW), .LOG_WAYS(LW)) u_plru_fill (
      .node_i      (plru_mem[fill_idx_q]),
      .touch_pos_i (vic_pos_q),
      .node_o      (fill_node_new),
      .victim_o    (repl_pos)
   );

   // Fill write comes last so it wins over a touch of the same line.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_FLUSH) begin
            plru_mem[flush_cnt_q[LL-1:0]] <= '0;
         end else begin
            if (touch_valid)         plru_mem[touch_index] <= touch_node_new;
            if (state_q == ST_WRITE) plru_mem[fill_idx_q]  <= fill_node_new;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_FLUSH) valid_mem[flush_cnt_q[LL-1:0]] <= '0;
         if (state_q == ST_WRITE) begin
            tag_mem[fill_idx_q][vic_pos_q]   <= fill_tag_q;
            valid_mem[fill_idx_q][vic_pos_q] <= 1'b1;
         end
      end
   end

   always_comb begin
      valid_lanes_d = valid_mem[lookup_index];
      tag_set_d     = '0;
      for (int w = 0; w < NW; w++) tag_set_d[w*TW +: TW] = tag_mem[lookup_index][w];
   end

   always_comb begin
      logic [NW-1:0] line_valid;
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      fill_idx_d   = fill_idx_q;
      fill_tag_d   = fill_tag_q;
      vic_pos_d    = vic_pos_q;
      vic_valid_d  = vic_valid_q;
      vic_tag_d    = vic_tag_q;
      flush_pend_d = flush_pend_q | flush_req;
      line_valid   = valid_mem[fill_idx_q];
      case (state_q)
         ST_FLUSH: begin
            flush_pend_d = 1'b0;
            flush_cnt_d  = flush_cnt_q + CNT_ONE;
            if (flush_req)             flush_cnt_d = '0;
            else if (flush_cnt_d[LL])  state_d     = ST_IDLE;
         end
         ST_IDLE: begin
            flush_pend_d = 1'b0;
            if (flush_req) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end else if (fill_valid) begin
               fill_idx_d = fill_index;
               fill_tag_d = fill_tag;
               state_d    = ST_VICTIM;
            end
         end
         ST_VICTIM: begin
            // Lowest invalid way beats the replacement policy.
            vic_pos_d   = repl_pos;
            vic_valid_d = 1'b1;
            for (int w = NW-1; w >= 0; w--) begin
               if (!line_valid[w]) begin
                  vic_pos_d   = LW'(w);
                  vic_valid_d = 1'b0;
               end
            end
            vic_tag_d = vic_valid_d ? tag_mem[fill_idx_q][vic_pos_d] : '0;
            state_d   = ST_WRITE;
         end
         ST_WRITE: begin
            if (flush_pend_q || flush_req) begin
               state_d      = ST_FLUSH;
               flush_cnt_d  = '0;
               flush_pend_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_FLUSH;
         flush_cnt_q   <= '0;
         fill_idx_q    <= '0;
         fill_tag_q    <= '0;
         vic_pos_q     <= '0;
         vic_valid_q   <= 1'b0;
         vic_tag_q     <= '0;
         flush_pend_q  <= 1'b0;
         tag_set_q     <= '0;
         valid_lanes_q <= '0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         fill_idx_q    <= fill_idx_d;
         fill_tag_q    <= fill_tag_d;
         vic_pos_q     <= vic_pos_d;
         vic_valid_q   <= vic_valid_d;
         vic_tag_q     <= vic_tag_d;
         flush_pend_q  <= flush_pend_d;
         tag_set_q     <= tag_set_d;
         valid_lanes_q <= valid_lanes_d;
      end
   end

   assign tag_set        = tag_set_q;
   assign valid_lanes    = valid_lanes_q;
   assign fill_ready     = (state_q == ST_IDLE);
   assign fill_done      = (state_q == ST_WRITE);
   assign fill_pos       = vic_pos_q;
   assign fill_evict     = vic_valid_q;
   assign fill_evict_tag = vic_tag_q;
   assign flush_busy     = (state_q == ST_FLUSH);

endmodule

// File: doc/tag_fill_controller.md
Name: tag_fill_controller

Overview:
- Write side of the set-associative tag path. It owns the per-line tag/valid store and the tree-PLRU state.
- Serves registered tag_set/valid_lanes words to the combinational hit detector, and records hits via a touch port.
- On a miss it accepts a fill request, picks a victim way, writes the new tag, and reports the way used and any evicted tag.
- Also performs a full-array invalidate (flush), both on request and automatically after reset.

Parameters:
- bits_for_tag, 20, tag width
- number_of_sets, 4, ways per line; power of two, at least 2
- log_of_number_of_sets, 2, log2(number_of_sets)
- number_of_lines, 64, lines (indices) in the store
- log_of_number_of_lines, 6, log2(number_of_lines)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- lookup_index  in  log_of_number_of_lines  line to read
- tag_set  out  bits_for_tag*number_of_sets  tags of lookup line; way i at [i*bits_for_tag +: bits_for_tag]
- valid_lanes  out  number_of_sets  valid bits of lookup line
- touch_valid  in  1  hit notification strobe
- touch_index  in  log_of_number_of_lines  line that hit
- touch_pos  in  log_of_number_of_sets  way that hit
- fill_valid  in  1  fill request
- fill_ready  out  1  fill accepted when fill_valid & fill_ready
- fill_index  in  log_of_number_of_lines  line to fill
- fill_tag  in  bits_for_tag  tag to install
- fill_done  out  1  one-cycle completion pulse
- fill_pos  out  log_of_number_of_sets  way written; valid with fill_done
- fill_evict  out  1  victim way was valid; valid with fill_done
- fill_evict_tag  out  bits_for_tag  replaced tag; valid with fill_done
- flush_req  in  1  invalidate-all request pulse
- flush_busy  out  1  flush in progress

Behaviour:
- Reset values: tag_set 0, valid_lanes 0, fill_ready 0, fill_done 0, fill_pos 0, fill_evict 0, fill_evict_tag 0, flush_busy 1. The flush counter is cleared and the state is set to FLUSH; the arrays themselves are not reset.
- Lookup: tag_set and valid_lanes update one cycle after lookup_index. The read reflects writes committed in earlier cycles; there is no same-cycle bypass.
- PLRU: each line holds number_of_sets-1 tree node bits. A node bit of 1 means the victim lies in the upper half.
  - Touching way w sets every node on w's path to point away from w.
  - The victim is found by following node bits from the root.
- Touch: when touch_valid is high, the PLRU update for touch_index/touch_pos is applied at the next edge. Touch is honoured in every state except FLUSH, where it is ignored.
- FSM states and transitions:
  - FLUSH: one line per cycle. valid bits and PLRU bits of line flush_cnt are cleared, and flush_cnt increments. After line number_of_lines-1 is cleared, go to IDLE. flush_busy is high throughout; fill_ready is 0.
  - IDLE: fill_ready=1.
    - flush_req has priority: go to FLUSH with counter 0.
    - Otherwise a fill handshake latches fill_index/fill_tag and goes to VICTIM.
  - VICTIM: read the latched line.
    - Victim is the lowest-numbered invalid way if any exists; otherwise the PLRU victim.
    - Register the victim's way, valid bit and tag.
    - Go to WRITE.
  - WRITE:
    - Write fill_tag into the victim way and set its valid bit.
    - Apply a PLRU touch of the victim way; on the same line this overrides a concurrent touch port update.
    - Pulse fill_done for this cycle, with fill_pos, fill_evict and fill_evict_tag valid.
    - Go to FLUSH if a flush is pending, else IDLE.
- Fill latency: fill_done asserts exactly 2 cycles after the accepting edge. fill_ready is low in VICTIM and WRITE.
- A flush_req arriving during VICTIM or WRITE is latched. It is not dropped, and the flush starts after WRITE.
- A flush_req during FLUSH restarts the counter at 0.
- Reset asserted mid-fill or mid-flush abandons the operation and re-enters FLUSH from line 0.
- Index arithmetic is unsigned, and flush_cnt is log_of_number_of_lines+1 bits wide to detect termination.

Optional Feature:
- TAG_FILL_RANDOM_REPL_EN defined:
  - When every way is valid, the victim is taken from the low log_of_number_of_sets bits of an 8-bit Fibonacci LFSR (taps 8,6,5,4).
  - The LFSR is seeded to 8'h01 on reset and advances every cycle.
  - PLRU storage and touch logic are not instantiated, and the touch port is ignored.
- Not defined: tree-PLRU as described above.
- Invalid-way-first selection applies in both modes.

Decomposition:
- Shared package holds:
  - the state encoding (FLUSH, IDLE, VICTIM, WRITE);
  - a PLRU node-count constant (number_of_sets-1);
  - the LFSR seed and tap mask.
- One sub-module, plru_tree: combinational. Takes node bits and a touched way, and produces the updated node bits and the victim way. It is instantiated twice, once for the touch port and once for the fill path.

Test Plan:
- Reset, then hold idle → flush_busy high for exactly 64 cycles and fill_ready=0 during that time. Afterwards, lookup_index=5 gives valid_lanes=4'b0000 one cycle later.
- Fill index 5 with tags 0xA0000, 0xA0001, 0xA0002, 0xA0003 back-to-back → fill_pos 0,1,2,3; fill_evict=0; each fill_done 2 cycles after its handshake; lookup of index 5 gives valid_lanes=4'b1111.
- Fill index 5 with tag 0xB0000 → fill_pos=0, fill_evict=1, fill_evict_tag=0xA0000.
- From the fully valid line after the first fill, touch way 0 then way 1, then fill tag 0xC0000 → fill_pos=2, fill_evict_tag=0xA0002. Without TAG_FILL_RANDOM_REPL_EN only.
- Assert flush_req in the VICTIM cycle of a fill → fill_done still pulses, then flush_busy for 64 cycles; afterwards all lines read valid_lanes=0.
- Assert reset for 1 cycle mid-flush (line 30) → flush restarts at line 0, flush_busy lasts 64 further cycles, and no fill_done pulses.
